// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone pipelined slave memory.
// One request accepted per cycle, responses (ack or err) returned in order
// after a fixed LATENCY, stall raised when MAX_OUTST responses are pending
// or when forced externally. Dropping cyc flushes every pending response.
module wb_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int MAX_OUTST   = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                wb_cyc_in,
  input  logic                wb_stb_in,
  input  logic                wb_we_in,
  input  logic [DATA_W/8-1:0] wb_be_in,
  input  logic [ADDR_W-1:0]   wb_addr_in,
  input  logic [DATA_W-1:0]   wb_data_in,
  output logic [DATA_W-1:0]   wb_data_out,
  output logic                wb_ack_out,
  output logic                wb_err_out,
  output logic                wb_stall_out,
  input  logic                stall_force_in
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_OUTST);

  logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [DATA_W-1:0]  r_data [LATENCY];
  logic [3:0]         r_outst;

  logic [IDX_W-1:0]   w_idx;
  logic [MEM_AW-1:0]  w_mem_idx;
  logic               w_in_range;
  logic               w_stall;
  logic               w_accept;
  logic               w_resp;

  assign w_idx      = wb_addr_in[ADDR_W-1:2];
  assign w_mem_idx  = w_idx[MEM_AW-1:0];
  assign w_in_range = (w_idx < DEPTH_IDX);

  assign w_stall    = stall_force_in | (r_outst == MAX_CNT);
  assign w_accept   = wb_cyc_in & wb_stb_in & ~w_stall;
  assign w_resp     = r_vld[LATENCY-1];

  // Responses are gated by cyc so a cycle that aborts emits nothing.
  assign wb_stall_out = w_stall;
  assign wb_ack_out   = w_resp & ~r_err[LATENCY-1] & wb_cyc_in;
  assign wb_err_out   = w_resp &  r_err[LATENCY-1] & wb_cyc_in;
  assign wb_data_out  = wb_ack_out ? r_data[LATENCY-1] : '0;

  // Byte-lane writes at the accept edge; out-of-range words never alias in.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && w_accept && wb_we_in && w_in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wb_be_in[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= wb_data_in[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures the accepted request, last stage drives the bus.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !wb_cyc_in) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_accept & ~w_in_range;
      r_data[0] <= (w_accept && !wb_we_in && w_in_range) ? r_mem[w_mem_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Outstanding count: a response frees its slot on the edge that ends its cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !wb_cyc_in) begin
      r_outst <= '0;
    end else if (w_accept && !w_resp) begin
      if (r_outst != 4'hF) begin
        r_outst <= r_outst + 4'd1;
      end
    end else if (!w_accept && w_resp) begin
      if (r_outst != 4'd0) begin
        r_outst <= r_outst - 4'd1;
      end
    end
  end

  // Stall must prevent any increment past the configured limit.
  a_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    (w_accept && !w_resp) |-> (r_outst < MAX_CNT));

  // ack and err are mutually exclusive.
  a_ack_err_excl: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(wb_ack_out && wb_err_out));

endmodule

// File: tb/tb_wb_mem_responder.sv
// Testbench for wb_mem_responder: driver pushes expected responses into a
// scoreboard queue, an independent monitor pops and compares them.
module tb_wb_mem_responder;

  localparam int LAT   = 3;
  localparam int MOUT  = 2;
  localparam int DEPTH = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wb_cyc_in, wb_stb_in, wb_we_in;
  logic [3:0]  wb_be_in;
  logic [31:0] wb_addr_in, wb_data_in;
  logic [31:0] wb_data_out;
  logic        wb_ack_out, wb_err_out, wb_stall_out;
  logic        stall_force_in;

  wb_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTST(MOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_be_in(wb_be_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out), .wb_ack_out(wb_ack_out), .wb_err_out(wb_err_out),
    .wb_stall_out(wb_stall_out), .stall_force_in(stall_force_in)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          pend[$];
  logic [31:0] mdl_mem [0:DEPTH-1];
  int          cyc_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One bus cycle: apply inputs, check stall against the model, update the model on accept.
  task automatic drive(input logic c, input logic s, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input logic f,
                       output logic acc);
    exp_t        e;
    int unsigned idx;
    logic        stall_exp;
    @(negedge sys_clk);
    wb_cyc_in = c; wb_stb_in = s; wb_we_in = w; wb_be_in = b;
    wb_addr_in = a; wb_data_in = d; stall_force_in = f;
    #1;
    while (pend.size() > 0 && pend[0] < cyc_n) void'(pend.pop_front());
    stall_exp = f || (pend.size() == MOUT);
    chk("stall", {31'd0, wb_stall_out}, {31'd0, stall_exp});
    acc = c && s && !stall_exp;
    if (acc) begin
      idx    = a >> 2;
      e.due  = cyc_n + LAT;
      e.err  = (idx >= DEPTH);
      e.data = '0;
      if (!e.err) begin
        if (w) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) mdl_mem[idx][8*k +: 8] = d[8*k +: 8];
        end else begin
          e.data = mdl_mem[idx];
        end
      end
      sb_q.push_back(e);
      pend.push_back(e.due);
    end
    if (!c) begin
      sb_q.delete();
      pend.delete();
    end
  endtask

  task automatic req(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    int   tries = 0;
    do begin
      drive(1'b1, 1'b1, w, b, a, d, 1'b0, acc);
      tries++;
    end while (!acc && tries < 20);
    chk("req_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
  endtask

  // Monitor: every cycle, a response must appear exactly when the oldest expectation is due.
  initial begin
    exp_t e;
    logic resp, due_now;
    forever begin
      @(negedge sys_clk);
      #2;
      if (mon_en) begin
        resp    = wb_ack_out | wb_err_out;
        due_now = (sb_q.size() > 0) && (sb_q[0].due == cyc_n);
        chk("ack_err_excl", {31'd0, wb_ack_out & wb_err_out}, 32'd0);
        chk("resp_present", {31'd0, resp}, {31'd0, due_now});
        if (resp && due_now) begin
          e = sb_q.pop_front();
          chk("resp_err", {31'd0, wb_err_out}, {31'd0, e.err});
          chk("resp_ack", {31'd0, wb_ack_out}, {31'd0, ~e.err});
          chk("resp_data", wb_data_out, e.data);
        end else if (!resp) begin
          chk("idle_data", wb_data_out, 32'd0);
        end
        while (sb_q.size() > 0 && sb_q[0].due <= cyc_n) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] a;
    sys_rst = 1'b1; wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
    wb_be_in = 4'h0; wb_addr_in = '0; wb_data_in = '0; stall_force_in = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    chk("rst_ack", {31'd0, wb_ack_out}, 32'd0);
    chk("rst_err", {31'd0, wb_err_out}, 32'd0);
    chk("rst_data", wb_data_out, 32'd0);
    chk("rst_stall", {31'd0, wb_stall_out}, 32'd0);
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    for (int i = 0; i < 16; i++) req(1'b1, 4'hF, 32'(i * 4), $urandom);

    // full write then read back
    req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    req(1'b0, 4'h0, 32'h10, 32'h0);
    // partial byte-enable write
    req(1'b1, 4'hF, 32'h20, 32'h11223344);
    req(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    req(1'b0, 4'h0, 32'h20, 32'h0);
    idle(6);
    chk("partial_write_model", mdl_mem[8], 32'h11BB33DD);
    // back-to-back reads against the outstanding limit
    for (int i = 0; i < 4; i++) req(1'b0, 4'h0, 32'(32'h30 + i * 4), 32'h0);
    idle(6);
    // out-of-range read and write, then check word 0 was not aliased
    req(1'b0, 4'h0, 32'h1000, 32'h0);
    req(1'b1, 4'hF, 32'h1000, 32'h12345678);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    idle(6);
    // abort with requests in flight
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h04, 32'h0, 1'b0, acc);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, acc);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0C, 32'h0, 1'b0, acc);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
    idle(3);
    req(1'b0, 4'h0, 32'h14, 32'h0);
    idle(6);
    // reset with two reads in flight
    req(1'b0, 4'h0, 32'h10, 32'h0);
    req(1'b0, 4'h0, 32'h14, 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b1; wb_stb_in = 1'b0;
    @(posedge sys_clk); #1;
    sb_q.delete();
    pend.delete();
    @(negedge sys_clk); #1;
    chk("midrst_ack", {31'd0, wb_ack_out}, 32'd0);
    chk("midrst_err", {31'd0, wb_err_out}, 32'd0);
    chk("midrst_data", wb_data_out, 32'd0);
    chk("midrst_stall", {31'd0, wb_stall_out}, 32'd0);
    sys_rst = 1'b0;
    req(1'b0, 4'h0, 32'h10, 32'h0);
    idle(6);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), a, $urandom, ($urandom_range(0, 9) == 0), acc);
    end

    for (int n = 0; n < 20 && sb_q.size() > 0; n++) idle(1);
    idle(2);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
